// File: rtl/stepper_move_ctrl.sv
// Move sequencer for a 4-coil stepper: latches a move command and steps the coil pattern every div+1 cycles.
// Define HALF_STEP_EN for the 8-entry half-step table; the default build uses the 4-entry full-step wave table.
module stepper_move_ctrl #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 8,
    parameter int POS_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             clockwise,
    input  logic [CNT_W-1:0] steps,
    input  logic [DIV_W-1:0] div,
    input  logic             hold,
    output logic [3:0]       q,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining,
    output logic [POS_W-1:0] position
);

`ifdef HALF_STEP_EN
    localparam int IDX_W = 3;
`else
    localparam int IDX_W = 2;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic [DIV_W-1:0] tick;
    logic [DIV_W-1:0] div_l;
    logic             cw_l;
    logic             moved;
    logic             load;
    logic             step;

    function automatic logic [3:0] phase_pattern(input logic [IDX_W-1:0] i);
        logic [3:0] p;
        p = 4'b0000;
`ifdef HALF_STEP_EN
        case (i)
            3'd0:    p = 4'b1000;
            3'd1:    p = 4'b1100;
            3'd2:    p = 4'b0100;
            3'd3:    p = 4'b0110;
            3'd4:    p = 4'b0010;
            3'd5:    p = 4'b0011;
            3'd6:    p = 4'b0001;
            default: p = 4'b1001;
        endcase
`else
        case (i)
            2'd0:    p = 4'b1000;
            2'd1:    p = 4'b0100;
            2'd2:    p = 4'b0010;
            default: p = 4'b0001;
        endcase
`endif
        return p;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        q         = 4'b0000;
        case (state)
            IDLE: begin
                if (start) begin
                    if (steps != '0) begin
                        state_nxt = RUN;
                        load      = 1'b1;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            RUN: begin
                busy = 1'b1;
                // An abort on the step cycle suppresses that step entirely.
                if (stop) begin
                    state_nxt = DONE;
                end else if (tick == div_l) begin
                    step = 1'b1;
                    if (remaining == CNT_W'(1)) state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Coils stay energised outside RUN only when asked to and a move has actually set the rotor.
        if (state == RUN || (hold && moved)) q = phase_pattern(idx);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx       <= '0;
            tick      <= '0;
            div_l     <= '0;
            cw_l      <= 1'b0;
            moved     <= 1'b0;
            remaining <= '0;
            position  <= '0;
        end else if (load) begin
            cw_l      <= clockwise;
            div_l     <= div;
            remaining <= steps;
            tick      <= '0;
            moved     <= 1'b1;
        end else if (step) begin
            tick      <= '0;
            remaining <= remaining - CNT_W'(1);
            if (cw_l) begin
                idx      <= idx + IDX_W'(1);
                position <= position + POS_W'(1);
            end else begin
                idx      <= idx - IDX_W'(1);
                position <= position - POS_W'(1);
            end
        end else if (state == RUN) begin
            tick <= tick + DIV_W'(1);
        end
    end

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Bench for stepper_move_ctrl: vector table, directed multi-cycle sequences and a randomized run against a step-time model.
module tb_stepper_move_ctrl;

`ifdef HALF_STEP_EN
    localparam int NPH = 8;
`else
    localparam int NPH = 4;
`endif

    logic        clk = 1'b0;
    logic        reset, start, stop, clockwise, hold;
    logic [7:0]  steps;
    logic [15:0] div;
    logic [3:0]  q;
    logic        busy, done;
    logic [7:0]  remaining;
    logic [15:0] position;

    int n_chk  = 0;
    int n_fail = 0;
    int idx_m  = 0;
    int pos_m  = 0;

    stepper_move_ctrl #(.DIV_W(16), .CNT_W(8), .POS_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clockwise(clockwise),
        .steps(steps), .div(div), .hold(hold), .q(q), .busy(busy), .done(done),
        .remaining(remaining), .position(position)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, st, sp, cw;
        logic [7:0]  stp;
        logic [15:0] dv;
        logic        hd;
        logic [3:0]  eq;
        logic        eb, ed;
        logic [7:0]  er;
        logic [15:0] ep;
    } vec_t;

    vec_t vt[9];

    function automatic logic [3:0] pat(input int i);
        logic [3:0] p;
`ifdef HALF_STEP_EN
        case (i)
            0: p = 4'b1000; 1: p = 4'b1100; 2: p = 4'b0100; 3: p = 4'b0110;
            4: p = 4'b0010; 5: p = 4'b0011; 6: p = 4'b0001; default: p = 4'b1001;
        endcase
`else
        case (i)
            0: p = 4'b1000; 1: p = 4'b0100; 2: p = 4'b0010; default: p = 4'b0001;
        endcase
`endif
        return p;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] eq, input logic eb, input logic ed,
                           input logic [7:0] er, input logic [15:0] ep);
        chk({tag, ".q"}, 32'(q), 32'(eq));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".done"}, 32'(done), 32'(ed));
        chk({tag, ".remaining"}, 32'(remaining), 32'(er));
        chk({tag, ".position"}, 32'(position), 32'(ep));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; stop = 1'b0; clockwise = 1'b0;
        steps = '0; div = '0; hold = 1'b0;
        tick(); tick();
        reset = 1'b1;
        idx_m = 0; pos_m = 0;
    endtask

    task automatic launch(input int n, input int d, input logic cw, input logic hd);
        start = 1'b1; steps = 8'(n); div = 16'(d); clockwise = cw; hold = hd; stop = 1'b0;
        tick();
        start = 1'b0;
    endtask

    // Expected behaviour from step times: step j lands on edge j*(d+1) after RUN entry; an abort
    // seen on edge s keeps only the steps strictly before it.
    task automatic rand_move();
        int n, d, s, endt, eff, k, ei;
        logic cw, hd, use_stop;
        n = $urandom_range(1, 12);
        d = $urandom_range(0, 3);
        cw = 1'($urandom_range(0, 1));
        hd = 1'($urandom_range(0, 1));
        use_stop = ($urandom_range(0, 3) == 0);
        s = use_stop ? $urandom_range(1, n * (d + 1)) : 0;
        endt = use_stop ? s : n * (d + 1);
        launch(n, d, cw, hd);
        k = 0;
        for (int t = 0; t <= endt + 1; t++) begin
            eff = (use_stop && t >= s) ? s - 1 : t;
            k = eff / (d + 1);
            if (k > n) k = n;
            ei = (idx_m + (cw ? k : NPH * 64 - k)) % NPH;
            chk_all("rand", (t < endt || hd) ? pat(ei) : 4'b0000, t < endt, t == endt,
                    8'(n - k), 16'(pos_m + (cw ? k : -k)));
            if (t <= endt) begin
                stop = use_stop && (t + 1 == s);
                // Command inputs and start pulses while busy or in DONE must be ignored.
                start = 1'($urandom_range(0, 1));
                steps = 8'($urandom);
                div = 16'($urandom_range(0, 7));
                clockwise = 1'($urandom_range(0, 1));
                tick();
            end
        end
        start = 1'b0; stop = 1'b0;
        idx_m = (idx_m + (cw ? k : NPH * 64 - k)) % NPH;
        pos_m = pos_m + (cw ? k : -k);
    endtask

    logic [3:0] seq_a[5];

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; clockwise = 1'b0;
        steps = '0; div = '0; hold = 1'b0;
        #1;

        // rst st sp cw stp dv hd | q busy done rem pos
        vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd0, 16'h0000};
        vt[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd0, 16'h0000};
        vt[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 16'd0, 1'b1, 4'b1000, 1'b1, 1'b0, 8'd2, 16'h0000};
        vt[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 16'd0, 1'b1, 4'b0001, 1'b1, 1'b0, 8'd1, 16'hFFFF};
        vt[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 16'd0, 1'b1, 4'b0010, 1'b0, 1'b1, 8'd0, 16'hFFFE};
        vt[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 16'd0, 1'b1, 4'b0010, 1'b0, 1'b0, 8'd0, 16'hFFFE};
        vt[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 4'b0010, 1'b0, 1'b1, 8'd0, 16'hFFFE};
        vt[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd0, 16'hFFFE};
        vt[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 16'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd0, 16'hFFFE};

        for (int i = 0; i < 9; i++) begin
            reset = vt[i].rst; start = vt[i].st; stop = vt[i].sp; clockwise = vt[i].cw;
            steps = vt[i].stp; div = vt[i].dv; hold = vt[i].hd;
            tick();
            chk_all($sformatf("vec%0d", i), vt[i].eq, vt[i].eb, vt[i].ed, vt[i].er, vt[i].ep);
        end

        // 5 steps, div=3, cw, hold: steps land every 4 cycles, coils held afterwards.
        seq_a = '{4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100};
        do_reset();
        launch(5, 3, 1'b1, 1'b1);
        chk_all("a.t0", 4'b1000, 1'b1, 1'b0, 8'd5, 16'd0);
        for (int t = 1; t <= 21; t++) begin
            tick();
            if (t % 4 == 0 && t <= 20) chk($sformatf("a.q%0d", t), 32'(q), 32'(seq_a[t / 4 - 1]));
            if (t == 3) chk("a.q3", 32'(q), 32'(4'b1000));
            if (t == 19) chk("a.done19", 32'(done), 32'd0);
            if (t == 20) chk_all("a.t20", 4'b0100, 1'b0, 1'b1, 8'd0, 16'd5);
            if (t == 21) chk_all("a.idle", 4'b0100, 1'b0, 1'b0, 8'd0, 16'd5);
        end

        // Abort coincident with the 3rd step: only two steps taken.
        do_reset();
        launch(10, 1, 1'b1, 1'b1);
        for (int t = 0; t < 6; t++) begin
            if (t == 5) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        chk_all("b.done", 4'b0010, 1'b0, 1'b1, 8'd8, 16'd2);
        tick();
        chk_all("b.idle", 4'b0010, 1'b0, 1'b0, 8'd8, 16'd2);

        // Reset in the middle of a 6-step move.
        do_reset();
        launch(6, 0, 1'b1, 1'b1);
        tick(); tick(); tick();
        chk_all("c.mid", 4'b0001, 1'b1, 1'b0, 8'd3, 16'd3);
        reset = 1'b0;
        tick();
        chk_all("c.rst", 4'b0000, 1'b0, 1'b0, 8'd0, 16'd0);
        reset = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk($sformatf("c.nodone%0d", t), 32'({busy, done}), 32'd0);
        end

        // Start held high while busy and in DONE is ignored.
        do_reset();
        launch(4, 2, 1'b1, 1'b0);
        start = 1'b1; steps = 8'd9;
        tick(); tick(); tick();
        chk_all("d.t3", 4'b0100, 1'b1, 1'b0, 8'd3, 16'd1);
        for (int t = 4; t <= 12; t++) tick();
        chk_all("d.done", 4'b0000, 1'b0, 1'b1, 8'd0, 16'd4);
        tick();
        start = 1'b0;
        chk_all("d.idle", 4'b0000, 1'b0, 1'b0, 8'd0, 16'd4);
        tick();
        chk_all("d.idle2", 4'b0000, 1'b0, 1'b0, 8'd0, 16'd4);

        do_reset();
        for (int m = 0; m < 40; m++) rand_move();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stepper_move_ctrl.md
Name: stepper_move_ctrl

Overview:
- Move sequencer for the 4-coil stepper motor on the lab board.
- Accepts a move command (step count, direction, speed divider) and drives the coil pattern q at a programmable step rate.
- Uses a clock-enable tick; no gated clock.
- Tracks absolute position and reports busy/done, so top-level logic can queue moves without touching the coil timing.

Parameters:
- DIV_W, 16, width of speed divider; step period = (div+1) clk cycles.
- CNT_W, 8, width of requested step count and remaining-steps counter.
- POS_W, 16, width of signed absolute position counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising clk, state cleared when 0.
- start  input  1  move request, honoured only in IDLE.
- stop  input  1  abort request, honoured only in RUN.
- clockwise  input  1  direction, latched at start; 1 = cw.
- steps  input  CNT_W  number of steps for the move, latched at start.
- div  input  DIV_W  speed divider, latched at start.
- hold  input  1  1 = keep coils energised in IDLE after a move; 0 = de-energise.
- q  output  4  coil drive pattern.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse at end of move (completed or aborted).
- remaining  output  CNT_W  steps still to execute.
- position  output  POS_W  signed absolute step position.

Behaviour:
- Reset values (reset=0 at edge):
  - state=IDLE, phase index=0, q=4'b0000, busy=0, done=0, remaining=0, position=0.
  - Tick counter=0 and all latched command registers cleared.
- Phase table, full-step wave drive, q by index: 0→1000, 1→0100, 2→0010, 3→0001.
  - cw step: index+1 mod 4 (3→0).
  - ccw step: index−1 mod 4 (0→3).
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and steps≠0 → RUN next cycle.
    - Latch clockwise, div, and remaining=steps; tick counter=0.
    - q=pattern(current index) from the first RUN cycle; the energise cycle is not a step.
  - start=1 and steps=0 → DONE next cycle, no motion.
  - q in IDLE = pattern(index) if hold=1 and at least one move has started since reset; else 0000.
- RUN:
  - Tick counter increments each cycle.
  - When counter==div_latched: step occurs.
    - Index advances.
    - position ±1 (wraps modulo 2^POS_W).
    - remaining−1, counter→0.
  - First step occurs div_latched+1 cycles after entering RUN; subsequent steps every div_latched+1 cycles.
  - div=0 gives one step per cycle.
  - Step that makes remaining=0 → DONE next cycle.
  - stop=1 → DONE next cycle.
    - stop wins over a coincident step: no step, remaining and position frozen.
- DONE:
  - done=1 for exactly one cycle, busy=0, then IDLE.
  - start during DONE ignored.
- busy=1 exactly while in RUN. start while busy ignored; stop outside RUN ignored.
- Inputs clockwise/div/steps changing during RUN have no effect.
- Reset asserted mid-move: next edge returns everything to reset values; no done pulse.

Optional Feature:
- Macro HALF_STEP_EN.
- Defined:
  - 8-entry half-step table, index 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
  - cw index+1 mod 8, ccw index−1 mod 8; each entry counts as one step for remaining and position.
- Undefined: 4-entry wave table above; index register 2 bits.

Test Plan:
- Reset: hold reset=0 two cycles → q=0000, busy=0, done=0, remaining=0, position=0.
- steps=5, div=3, cw, hold=1:
  - Steps at cycles 4, 8, 12, 16, 20 after RUN entry.
  - q 1000→0100→0010→0001→1000→0100.
  - position=5; done pulse one cycle after the 5th step; q stays 0100 in IDLE.
- steps=2, div=0, ccw from index 0:
  - q 1000→0001→0010 on consecutive cycles.
  - position=−2 (16'hFFFE); busy high exactly 2 cycles.
- steps=10, div=1, stop asserted on the cycle of the 3rd step:
  - Only 2 steps taken, remaining=8, position=2.
  - done pulses once, next cycle IDLE.
- steps=0 start → done pulse next cycle, busy never high, q unchanged.
- Reset mid-move:
  - Apply reset=0 during RUN at step 3 of 6 → all outputs return to reset values, no done pulse.
  - A start during busy in a separate run is ignored, remaining unaffected.
